// File: rtl/conv_maxpool_pkg.sv
// Shared types for the convolution / pooling pipeline: geometry defaults, pooling FSM states, signed result type.
// Purely declarative; no logic here beyond a signed max helper.
// No handshake; consumed by conv_maxpool and pool_max4.
package conv_pkg;

    localparam int DATA_W  = 16;
    localparam int ROW_LEN = 6;
    localparam int ROWS    = 6;
    localparam int RCNT_W  = $clog2(ROWS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2,
        HOLD = 2'd3
    } state_t;

    typedef logic signed [DATA_W-1:0] result_t;
    typedef result_t [ROW_LEN-1:0]    row_t;
    typedef result_t [ROW_LEN/2-1:0]  pool_t;

    function automatic result_t smax(input result_t a, input result_t b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

endpackage

// File: rtl/conv_maxpool_if.sv
// Row-in / pooled-row-out handshake bundle between the conv stage, the pooling stage and downstream.
// No latency of its own.
// row_vld/row_rdy and out_vld/out_rdy carry the backpressure.
interface conv_maxpool_if;
    import conv_pkg::*;

    logic  in_st;
    logic  row_vld;
    row_t  row_data;
    logic  row_rdy;
    pool_t dout;
    logic  out_vld;
    logic  out_rdy;
    logic  out_st;

    modport master (
        output in_st, row_vld, row_data, out_rdy,
        input  row_rdy, dout, out_vld, out_st
    );

    modport slave (
        input  in_st, row_vld, row_data, out_rdy,
        output row_rdy, dout, out_vld, out_st
    );
endinterface

// File: rtl/conv_maxpool_pool_max4.sv
// pool_max4: signed 4-input max tree; CONV_POOL_RELU_EN clamps negative results to zero.
// Latency: combinational.
// Backpressure: none.
module pool_max4
    import conv_pkg::*;
(
    input  result_t a,
    input  result_t b,
    input  result_t c,
    input  result_t d,
    output result_t y
);
    result_t m;

    always_comb begin
        m = smax(smax(a, b), smax(c, d));
`ifdef CONV_POOL_RELU_EN
        y = (m < 0) ? '0 : m;
`else
        y = m;
`endif
    end
endmodule

// File: rtl/conv_maxpool.sv
// conv_maxpool: 2x2 stride-2 max pooling of conv result rows (CONV_POOL_RELU_EN selects ReLU on pooled values).
// Latency: pooled row valid the cycle after its odd input row is accepted; out_st the cycle after the frame's last pooled row is taken.
// Backpressure: row_rdy is low while a pooled row waits on out_rdy; in_st always aborts and restarts the frame.
module conv_maxpool
    import conv_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    conv_maxpool_if.slave bus
);
    state_t            state_q, state_d;
    logic [RCNT_W-1:0] rcnt_q;
    row_t              even_q;
    pool_t             dout_q;
    pool_t             pooled;
    logic              out_st_q;
    logic              row_rdy_w, out_vld_w;
    logic              row_acc, out_acc, last_row;

    assign row_rdy_w = (state_q == EVEN) || (state_q == ODD);
    assign out_vld_w = (state_q == HOLD);
    assign row_acc   = bus.row_vld && row_rdy_w;
    assign out_acc   = out_vld_w && bus.out_rdy;
    assign last_row  = (rcnt_q == RCNT_W'(ROWS));

    assign bus.row_rdy = row_rdy_w;
    assign bus.out_vld = out_vld_w;
    assign bus.dout    = dout_q;
    assign bus.out_st  = out_st_q;

    // Odd row is pooled straight off the bus against the buffered even row.
    for (genvar k = 0; k < ROW_LEN/2; k++) begin : g_pool
        pool_max4 u_max (
            .a (even_q[2*k]),
            .b (even_q[2*k+1]),
            .c (bus.row_data[2*k]),
            .d (bus.row_data[2*k+1]),
            .y (pooled[k])
        );
    end

    always_comb begin
        state_d = state_q;
        if (bus.in_st) begin
            state_d = EVEN;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                EVEN:    if (row_acc) state_d = ODD;
                ODD:     if (row_acc) state_d = HOLD;
                HOLD:    if (out_acc) state_d = last_row ? IDLE : EVEN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rcnt_q   <= '0;
            even_q   <= '0;
            dout_q   <= '0;
            out_st_q <= 1'b0;
        end else begin
            out_st_q <= 1'b0;
            if (bus.in_st) begin
                rcnt_q <= '0;
                even_q <= '0;
            end else begin
                case (state_q)
                    EVEN: if (row_acc) begin
                        even_q <= bus.row_data;
                        rcnt_q <= rcnt_q + RCNT_W'(1);
                    end
                    ODD: if (row_acc) begin
                        dout_q <= pooled;
                        rcnt_q <= rcnt_q + RCNT_W'(1);
                    end
                    HOLD: if (out_acc && last_row) begin
                        out_st_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_conv_maxpool.sv
// Randomised self-checking bench for conv_maxpool against a plain-arithmetic 2x2 max-pool model.
module tb_conv_maxpool;
    import conv_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    conv_maxpool_if bus ();

    conv_maxpool dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic pool_t ref_pool(input row_t e, input row_t o);
        pool_t r;
        int    q[4];
        int    m;
        r = '0;
        for (int k = 0; k < ROW_LEN/2; k++) begin
            q[0] = int'($signed(e[2*k]));
            q[1] = int'($signed(e[2*k+1]));
            q[2] = int'($signed(o[2*k]));
            q[3] = int'($signed(o[2*k+1]));
            m = q[0];
            for (int j = 1; j < 4; j++) if (q[j] > m) m = q[j];
`ifdef CONV_POOL_RELU_EN
            if (m < 0) m = 0;
`endif
            r[k] = result_t'(m);
        end
        return r;
    endfunction

    function automatic row_t rnd_row();
        row_t r;
        int   v;
        for (int c = 0; c < ROW_LEN; c++) begin
            case ($urandom_range(0, 5))
                0:       v = -32768;
                1:       v = 32767;
                default: v = int'($urandom_range(0, 65535)) - 32768;
            endcase
            r[c] = result_t'(v);
        end
        return r;
    endfunction

    task automatic start_frame();
        bus.in_st = 1'b1;
        @(negedge clk);
        bus.in_st = 1'b0;
    endtask

    task automatic push_row(input row_t r, output bit ok);
        ok = 1'b0;
        bus.row_vld  = 1'b1;
        bus.row_data = r;
        for (int i = 0; i < 50 && !bus.row_rdy; i++) @(negedge clk);
        if (bus.row_rdy) begin
            @(posedge clk);
            @(negedge clk);
            ok = 1'b1;
        end
        bus.row_vld = 1'b0;
    endtask

    task automatic pull_out(input int stall, output pool_t d, output bit ok);
        ok = 1'b0;
        d  = '0;
        for (int i = 0; i < 50 && !bus.out_vld; i++) @(negedge clk);
        if (!bus.out_vld) return;
        repeat (stall) @(negedge clk);
        d = bus.dout;
        bus.out_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_rdy = 1'b0;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (bus.out_vld !== 1'b0 || bus.row_rdy !== 1'b0 || bus.out_st !== 1'b0 || bus.dout !== '0) begin
            errors++;
            $display("FAIL reset_state got vld=%b rdy=%b st=%b dout=%h want 0 0 0 0",
                     bus.out_vld, bus.row_rdy, bus.out_st, bus.dout);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.row_rdy !== 1'b0) begin
            errors++;
            $display("FAIL idle_rdy got %b want 0", bus.row_rdy);
        end
    endtask

    task automatic test_full_frame();
        int    exp_tab[3][3] = '{'{7, 9, 11}, '{19, 21, 23}, '{31, 33, 35}};
        row_t  e, o;
        pool_t d, x;
        bit    ok1, ok2, ok3;
        start_frame();
        checks++;
        if (bus.row_rdy !== 1'b1) begin
            errors++;
            $display("FAIL start_rdy got %b want 1", bus.row_rdy);
        end
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < ROW_LEN; c++) begin
                e[c] = result_t'((2*p) * 6 + c);
                o[c] = result_t'((2*p + 1) * 6 + c);
            end
            for (int k = 0; k < 3; k++) x[k] = result_t'(exp_tab[p][k]);
            push_row(e, ok1);
            push_row(o, ok2);
            checks++;
            if (bus.out_vld !== 1'b1) begin
                errors++;
                $display("FAIL ff_latency_p%0d got out_vld=%b want 1", p, bus.out_vld);
            end
            pull_out(0, d, ok3);
            checks++;
            if (!(ok1 && ok2 && ok3) || d !== x) begin
                errors++;
                $display("FAIL ff_row_p%0d got %h (ok %b%b%b) want %h", p, d, ok1, ok2, ok3, x);
            end
            checks++;
            if (bus.out_st !== (p == 2)) begin
                errors++;
                $display("FAIL ff_out_st_p%0d got %b want %b", p, bus.out_st, p == 2);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.out_st !== 1'b0 || bus.row_rdy !== 1'b0) begin
            errors++;
            $display("FAIL ff_post got st=%b rdy=%b want 0 0", bus.out_st, bus.row_rdy);
        end
    endtask

    task automatic test_idle_row_vld();
        bit bad = 1'b0;
        bus.row_vld  = 1'b1;
        bus.row_data = rnd_row();
        repeat (10) begin
            @(negedge clk);
            if (bus.row_rdy !== 1'b0 || bus.out_vld !== 1'b0) bad = 1'b1;
        end
        bus.row_vld = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL idle_row_vld got accept/output activity want none");
        end
    endtask

    task automatic test_signed();
        row_t  e, o;
        pool_t d, x;
        bit    ok1, ok2, ok3;
        int    exp0, exp2;
`ifdef CONV_POOL_RELU_EN
        exp0 = 0;
        exp2 = 0;
`else
        exp0 = -1;
        exp2 = -7;
`endif
        e[0] = -16'sd5;     e[1] = -16'sd1;     o[0] = -16'sd32768; o[1] = -16'sd2;
        e[2] = 16'sd32767;  e[3] = -16'sd32768; o[2] = 16'sd0;      o[3] = 16'sd0;
        e[4] = -16'sd7;     e[5] = -16'sd7;     o[4] = -16'sd7;     o[5] = -16'sd7;
        x[0] = result_t'(exp0);
        x[1] = result_t'(32767);
        x[2] = result_t'(exp2);
        start_frame();
        push_row(e, ok1);
        push_row(o, ok2);
        pull_out(1, d, ok3);
        checks++;
        if (!(ok1 && ok2 && ok3) || d !== x) begin
            errors++;
            $display("FAIL signed_quads got %h want %h", d, x);
        end
    endtask

    task automatic test_backpressure();
        row_t  e, o;
        pool_t d, d0;
        bit    ok1, ok2, ok3;
        e = rnd_row();
        o = rnd_row();
        start_frame();
        push_row(e, ok1);
        push_row(o, ok2);
        d0 = bus.dout;
        checks++;
        if (!(ok1 && ok2) || bus.out_vld !== 1'b1 || d0 !== ref_pool(e, o)) begin
            errors++;
            $display("FAIL bp_first got vld=%b dout=%h want 1 %h", bus.out_vld, d0, ref_pool(e, o));
        end
        bus.row_vld  = 1'b1;
        bus.row_data = rnd_row();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.dout !== d0 || bus.row_rdy !== 1'b0 || bus.out_vld !== 1'b1) begin
                errors++;
                $display("FAIL bp_stall_c%0d got dout=%h rdy=%b vld=%b want %h 0 1",
                         i, bus.dout, bus.row_rdy, bus.out_vld, d0);
            end
            @(negedge clk);
        end
        bus.row_vld = 1'b0;
        pull_out(0, d, ok3);
        checks++;
        if (!ok3 || d !== d0 || bus.out_st !== 1'b0 || bus.row_rdy !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got dout=%h st=%b rdy=%b want %h 0 1", d, bus.out_st, bus.row_rdy, d0);
        end
    endtask

    task automatic test_abort();
        row_t  r[6];
        pool_t d;
        bit    ok1, ok2, ok3;
        start_frame();
        for (int i = 0; i < 6; i++) r[i] = rnd_row();
        push_row(r[0], ok1);
        push_row(r[1], ok2);
        pull_out(0, d, ok3);
        push_row(r[2], ok1);
        start_frame();
        checks++;
        if (bus.out_vld !== 1'b0 || bus.row_rdy !== 1'b1) begin
            errors++;
            $display("FAIL abort_odd got vld=%b rdy=%b want 0 1", bus.out_vld, bus.row_rdy);
        end
        for (int i = 0; i < 4; i++) r[i] = rnd_row();
        push_row(r[0], ok1);
        push_row(r[1], ok2);
        pull_out(0, d, ok3);
        checks++;
        if (!(ok1 && ok2 && ok3) || d !== ref_pool(r[0], r[1])) begin
            errors++;
            $display("FAIL abort_new_data got %h want %h", d, ref_pool(r[0], r[1]));
        end
        push_row(r[2], ok1);
        push_row(r[3], ok2);
        bus.in_st   = 1'b1;
        bus.out_rdy = 1'b1;
        @(negedge clk);
        bus.in_st   = 1'b0;
        bus.out_rdy = 1'b0;
        checks++;
        if (bus.out_vld !== 1'b0 || bus.out_st !== 1'b0 || bus.row_rdy !== 1'b1) begin
            errors++;
            $display("FAIL abort_hold got vld=%b st=%b rdy=%b want 0 0 1", bus.out_vld, bus.out_st, bus.row_rdy);
        end
        for (int i = 0; i < 6; i++) r[i] = rnd_row();
        for (int p = 0; p < ROWS/2; p++) begin
            push_row(r[2*p], ok1);
            push_row(r[2*p+1], ok2);
            pull_out(0, d, ok3);
            checks++;
            if (!(ok1 && ok2 && ok3) || d !== ref_pool(r[2*p], r[2*p+1]) || bus.out_st !== (p == ROWS/2 - 1)) begin
                errors++;
                $display("FAIL abort_restart_p%0d got %h st=%b want %h st=%b",
                         p, d, bus.out_st, ref_pool(r[2*p], r[2*p+1]), p == ROWS/2 - 1);
            end
        end
    endtask

    task automatic test_random();
        row_t  e, o;
        pool_t d;
        bit    ok1, ok2, ok3;
        for (int f = 0; f < 4; f++) begin
            start_frame();
            for (int p = 0; p < ROWS/2; p++) begin
                e = rnd_row();
                o = rnd_row();
                push_row(e, ok1);
                push_row(o, ok2);
                pull_out(int'($urandom_range(0, 4)), d, ok3);
                checks++;
                if (!(ok1 && ok2 && ok3) || d !== ref_pool(e, o) || bus.out_st !== (p == ROWS/2 - 1)) begin
                    errors++;
                    $display("FAIL rand_f%0d_p%0d got %h st=%b want %h st=%b",
                             f, p, d, bus.out_st, ref_pool(e, o), p == ROWS/2 - 1);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        row_t  e, o;
        pool_t d;
        bit    ok1, ok2, ok3;
        start_frame();
        push_row(rnd_row(), ok1);
        push_row(rnd_row(), ok2);
        reset = 1'b0;
        #1;
        checks++;
        if (bus.out_vld !== 1'b0 || bus.row_rdy !== 1'b0 || bus.dout !== '0 || bus.out_st !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got vld=%b rdy=%b dout=%h st=%b want 0 0 0 0",
                     bus.out_vld, bus.row_rdy, bus.dout, bus.out_st);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        e = rnd_row();
        o = rnd_row();
        start_frame();
        push_row(e, ok1);
        push_row(o, ok2);
        pull_out(0, d, ok3);
        checks++;
        if (!(ok1 && ok2 && ok3) || d !== ref_pool(e, o)) begin
            errors++;
            $display("FAIL reset_mid_restart got %h want %h", d, ref_pool(e, o));
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b0;
        bus.in_st    = 1'b0;
        bus.row_vld  = 1'b0;
        bus.row_data = '0;
        bus.out_rdy  = 1'b0;
        test_reset();
        test_full_frame();
        test_idle_row_vld();
        test_signed();
        test_backpressure();
        test_abort();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_maxpool.md
# conv_maxpool

2x2 stride-2 max-pooling stage directly downstream of the 2D convolution processor. It consumes the convolution result one row per handshake (ROWS rows of ROW_LEN signed DATA_W values) and buffers each even row. On each odd row it emits one pooled row of ROW_LEN/2 values over a valid/ready handshake. One frame of ROWS x ROW_LEN results therefore yields ROWS/2 pooled rows.

## Interface
- DATA_W, 16: width of each signed conv result and pooled value
- ROW_LEN, 6: results per input row; must be even
- ROWS, 6: input rows per frame; must be even
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- in_st  in  1  frame-start pulse from the convolution stage
- row_vld  in  1  row_data valid
- row_data  in  ROW_LEN x DATA_W signed  one conv result row, index 0 = leftmost column
- row_rdy  out  1  stage accepts a row this cycle
- dout  out  ROW_LEN/2 x DATA_W signed  pooled row
- out_vld  out  1  dout valid
- out_rdy  in  1  downstream accepts dout
- out_st  out  1  one-cycle pulse: last pooled row of the frame accepted

## Operation
- States: IDLE, EVEN (awaiting an even-indexed row), ODD (awaiting an odd-indexed row), HOLD (pooled row pending, not yet accepted).
- IDLE: row_rdy=0. in_st=1 -> EVEN; row counter rcnt=0.
- EVEN: row_rdy=1. On row_vld&row_rdy, row_data -> even buffer; rcnt+1 -> ODD.
- ODD: row_rdy=1. On accept, dout[k] <= max(even[2k], even[2k+1], row_data[2k], row_data[2k+1]) for k=0..ROW_LEN/2-1. Set out_vld=1, rcnt+1 -> HOLD.
- HOLD: row_rdy=0. On out_vld&out_rdy, out_vld<=0.
  - If rcnt==ROWS: out_st pulse, -> IDLE.
  - Otherwise -> EVEN.
- Comparisons are signed two's complement. Ties return the common value. No width growth: dout is DATA_W.
- in_st in any non-IDLE state aborts the frame: out_vld<=0, even buffer content discarded, rcnt=0, -> EVEN. No out_st is issued for the aborted frame.
- row_vld in IDLE or HOLD is not accepted; the upstream stage holds row_data stable until accepted.
- dout holds its value while out_vld=1. After acceptance, dout keeps its last value (don't-care).

## Timing
- Reset (reset=0, asynchronous): state=IDLE, rcnt=0, row_rdy=0, out_vld=0, out_st=0, dout=all zeros, even buffer=zeros.
- in_st sampled at cycle N -> row_rdy=1 at N+1.
- Latency: odd row accepted at edge N -> out_vld=1 and dout valid after edge N, i.e. one cycle.
- Pooled row accepted at edge M -> row_rdy=1 in cycle after M (EVEN), or out_st=1 in cycle after M for the last row.
- Throughput without backpressure: 3 cycles per pooled row (even accept, odd accept, output accept).
- out_st is high for exactly one cycle and coincides with the return to IDLE.
- in_st and out_vld&out_rdy in the same cycle: in_st wins (abort/restart). The handshake still counts as consumed downstream, but no out_st is issued.

## Configuration
- CONV_POOL_RELU_EN defined: each pooled value is max(pool, 0), so negative pooled results output 0.
- CONV_POOL_RELU_EN undefined: raw signed maximum is output.
- Timing, latency and handshakes are identical in both builds.

## Structure
- Shared package conv_pkg holds:
  - DATA_W, ROW_LEN, ROWS defaults
  - the state enum (IDLE/EVEN/ODD/HOLD)
  - the signed result typedef used by the convolution stage and this block
- One combinational sub-module, pool_max4: a signed 4-input max tree with optional ReLU. It is instantiated ROW_LEN/2 times via generate.

## Test plan
- Reset mid-frame: drop reset during HOLD -> out_vld=0, row_rdy=0, dout=0 immediately; next in_st starts a clean frame.
- Full frame, no backpressure, out_rdy=1: row r holds value r*6+c (column c) -> pooled rows {7,9,11},{19,21,23},{31,33,35}; out_st pulses once, 1 cycle after the third acceptance.
- Signed compare: quad {-5,-1,-32768,-2} -> -1. With CONV_POOL_RELU_EN: 0. Quad {32767,-32768,0,0} -> 32767.
- Backpressure: out_rdy=0 for 5 cycles after out_vld -> dout stable, row_rdy=0, next row_vld not accepted; proceeds after out_rdy=1.
- Abort: in_st after 3 accepted rows -> out_vld=0, rcnt=0. The next frame's first pooled row uses only new data; no out_st for the aborted frame.
- row_vld asserted in IDLE with no in_st -> never accepted, no output.
